// File: rtl/sd_readout_sched.sv
`timescale 1ns/1ps
// sd_readout_sched
//
// Sequencer for the SD-to-STM readout path. A start command latches a first
// block address and a block count (0 = unbounded). The readout FIFO is
// flushed and then single-block read requests with consecutive addresses are
// issued to the SD readout datapath. A request is raised only when the FIFO
// has room for a whole block. The STM-facing data-ready flag follows the FIFO
// fill level in every state. The block also reports sticky errors and counts
// completed blocks.
//
// Optional feature: define SDREADOUT_SCHED_TIMEOUT_EN to enable an SD
// watchdog. A wait for sd_ack or sd_done that lasts TIMEOUT_CYCLES cycles is
// treated like sd_err.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   cmd_start    one-cycle pulse, begin readout (ignored while busy)
//   cmd_addr     first SD block address, sampled with cmd_start
//   cmd_count    block count, 0 = unbounded, sampled with cmd_start
//   cmd_stop     one-cycle pulse, end readout
//   sd_req       block read request, held until sd_ack
//   sd_addr      block address, stable while sd_req=1
//   sd_ack       datapath accepted the request
//   sd_done      one-cycle pulse, block fully written to the FIFO
//   sd_err       one-cycle pulse, CRC or response error
//   fifo_level   FIFO occupancy in words
//   fifo_rst     one-cycle FIFO flush pulse
//   busy         readout in progress
//   d_ready      registered (fifo_level >= CHUNK_WORDS)
//   err          sticky error flag, cleared by an accepted start
//   blocks_done  blocks completed since last start, wraps at 2^16

module sd_readout_sched #(
  parameter int BLOCK_WORDS    = 256,
  parameter int FIFO_DEPTH     = 1024,
  parameter int CHUNK_WORDS    = 256,
  parameter int LEVEL_W        = 11,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_start,
  input  logic [31:0]        cmd_addr,
  input  logic [15:0]        cmd_count,
  input  logic               cmd_stop,
  output logic               sd_req,
  output logic [31:0]        sd_addr,
  input  logic               sd_ack,
  input  logic               sd_done,
  input  logic               sd_err,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_rst,
  output logic               busy,
  output logic               d_ready,
  output logic               err,
  output logic [15:0]        blocks_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_ISSUE,
    S_WAIT_ACK,
    S_XFER,
    S_STOPPING
  } state_t;

  // A block fits when FIFO_DEPTH - fifo_level >= BLOCK_WORDS, rewritten so
  // that no subtraction on the live level can underflow.
  localparam logic [31:0] SPACE_MAX = 32'(FIFO_DEPTH - BLOCK_WORDS);
  localparam logic [31:0] CHUNK_MIN = 32'(CHUNK_WORDS);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [15:0] remain_q;
  logic        bounded_q;
  logic        stop_pend_q;   // STOPPING entered with the request not yet acked
  logic        err_q;
  logic [15:0] blocks_q;
  logic        d_ready_q;

  logic [31:0] level_ext;
  logic        space_ok;
  logic        in_wait;
  logic        wd_expired;
  logic        fault;
  logic        start_evt;
  logic        done_evt;
  logic        last_blk;

  assign level_ext = 32'(fifo_level);
  assign space_ok  = (level_ext <= SPACE_MAX);
  assign in_wait   = (state_q == S_WAIT_ACK) || (state_q == S_XFER) ||
                     (state_q == S_STOPPING);
  assign fault     = in_wait && (sd_err || wd_expired);
  assign start_evt = (state_q == S_IDLE) && cmd_start && !cmd_stop;
  assign done_evt  = !fault && sd_done &&
                     ((state_q == S_XFER) ||
                      ((state_q == S_STOPPING) && !stop_pend_q));
  assign last_blk  = bounded_q && (remain_q == 16'd1);

`ifdef SDREADOUT_SCHED_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_cnt_q;
  logic        wd_restart;

  // Every new wait starts from zero: any state change, or the ack that moves
  // STOPPING from waiting for sd_ack to waiting for sd_done.
  assign wd_restart = (state_d != state_q) ||
                      ((state_q == S_STOPPING) && stop_pend_q && sd_ack);
  assign wd_expired = in_wait && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else if (wd_restart) begin
      wd_cnt_q <= '0;
    end else if (in_wait && !wd_expired) begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end
  end
`else
  logic wd_unused;
  assign wd_unused  = (TIMEOUT_CYCLES != 0);
  assign wd_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_evt) state_d = S_FLUSH;
      end
      // A stop arriving during the flush cycle is honoured rather than lost.
      S_FLUSH: begin
        state_d = cmd_stop ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        if (cmd_stop)      state_d = S_IDLE;
        else if (space_ok) state_d = S_WAIT_ACK;
      end
      // A raised request stays up through a stop until it is acked.
      S_WAIT_ACK: begin
        if (fault)         state_d = S_IDLE;
        else if (cmd_stop) state_d = S_STOPPING;
        else if (sd_ack)   state_d = S_XFER;
      end
      // A stop coinciding with sd_done ends at once; no block is outstanding.
      S_XFER: begin
        if (fault)         state_d = S_IDLE;
        else if (sd_done)  state_d = (last_blk || cmd_stop) ? S_IDLE : S_ISSUE;
        else if (cmd_stop) state_d = S_STOPPING;
      end
      S_STOPPING: begin
        if (fault || done_evt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address, count, progress and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remain_q    <= '0;
      bounded_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
      blocks_q    <= '0;
      d_ready_q   <= 1'b0;
    end else begin
      d_ready_q <= (level_ext >= CHUNK_MIN);

      if (start_evt) begin
        addr_q    <= cmd_addr;
        remain_q  <= cmd_count;
        bounded_q <= (cmd_count != 16'd0);
        err_q     <= 1'b0;
        blocks_q  <= '0;
      end else if (done_evt) begin
        addr_q   <= addr_q + 32'd1;
        blocks_q <= blocks_q + 16'd1;
        if (bounded_q) remain_q <= remain_q - 16'd1;
      end

      if (fault) err_q <= 1'b1;

      if (state_d == S_IDLE) begin
        stop_pend_q <= 1'b0;
      end else if ((state_q == S_WAIT_ACK) && (state_d == S_STOPPING)) begin
        stop_pend_q <= !sd_ack;
      end else if ((state_q == S_STOPPING) && sd_ack) begin
        stop_pend_q <= 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    sd_req      = (state_q == S_WAIT_ACK) ||
                  ((state_q == S_STOPPING) && stop_pend_q);
    busy        = (state_q != S_IDLE);
    fifo_rst    = (state_q == S_FLUSH);
    sd_addr     = addr_q;
    err         = err_q;
    blocks_done = blocks_q;
    d_ready     = d_ready_q;
  end

endmodule

// File: tb/tb_sd_readout_sched.sv
`timescale 1ns/1ps
module tb_sd_readout_sched;

  localparam int LW = 11;
  localparam int TO = 65535;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_start;
  logic [31:0]   cmd_addr;
  logic [15:0]   cmd_count;
  logic          cmd_stop;
  logic          sd_req;
  logic [31:0]   sd_addr;
  logic          sd_ack;
  logic          sd_done;
  logic          sd_err;
  logic [LW-1:0] fifo_level;
  logic          fifo_rst;
  logic          busy;
  logic          d_ready;
  logic          err;
  logic [15:0]   blocks_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sd_readout_sched #(
    .BLOCK_WORDS(256), .FIFO_DEPTH(1024), .CHUNK_WORDS(256),
    .LEVEL_W(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
    .cmd_count(cmd_count), .cmd_stop(cmd_stop), .sd_req(sd_req),
    .sd_addr(sd_addr), .sd_ack(sd_ack), .sd_done(sd_done), .sd_err(sd_err),
    .fifo_level(fifo_level), .fifo_rst(fifo_rst), .busy(busy),
    .d_ready(d_ready), .err(err), .blocks_done(blocks_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] c);
    cmd_addr  = a;
    cmd_count = c;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_start = 0; cmd_stop = 0; cmd_addr = 0; cmd_count = 0;
    sd_ack = 0; sd_done = 0; sd_err = 0; fifo_level = '0;
    repeat (2) step();
    checks++;
    if ({sd_req, fifo_rst, busy, d_ready, err, blocks_done, sd_addr} !== 53'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b rst=%0b busy=%0b rdy=%0b err=%0b blk=%0d addr=%0h expected all 0",
               sd_req, fifo_rst, busy, d_ready, err, blocks_done, sd_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_bounded_read();
    fifo_level = '0;
    pulse_start(32'h100, 16'd3);
    checks++;
    if ({fifo_rst, busy} !== 2'b11) begin
      errors++; $display("FAIL start_flags: fifo_rst,busy=%b expected 11", {fifo_rst, busy});
    end
    step();
    checks++;
    if (fifo_rst !== 1'b0) begin
      errors++; $display("FAIL flush_pulse_len: fifo_rst=%0b expected 0", fifo_rst);
    end
    step();
    checks++;
    if (sd_req !== 1'b1) begin
      errors++; $display("FAIL first_req_latency: sd_req=%0b expected 1", sd_req);
    end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (sd_addr !== 32'h100 + 32'(b)) begin
        errors++; $display("FAIL bounded_addr: sd_addr=%0h expected %0h", sd_addr, 32'h100 + 32'(b));
      end
      step(); step();
      sd_ack = 1'b1; step(); sd_ack = 1'b0;
      checks++;
      if (sd_req !== 1'b0) begin
        errors++; $display("FAIL req_drop_after_ack: sd_req=%0b expected 0", sd_req);
      end
      repeat (19) step();
      sd_done = 1'b1; step(); sd_done = 1'b0;
      checks++;
      if (blocks_done !== 16'(b + 1)) begin
        errors++; $display("FAIL blocks_done_count: blocks_done=%0d expected %0d", blocks_done, b + 1);
      end
      if (b < 2) begin
        checks++;
        if ({sd_req, busy} !== 2'b01) begin
          errors++; $display("FAIL req_gap_after_done: req,busy=%b expected 01", {sd_req, busy});
        end
        step();
        checks++;
        if (sd_req !== 1'b1) begin
          errors++; $display("FAIL next_req_latency: sd_req=%0b expected 1", sd_req);
        end
      end else begin
        checks++;
        if ({sd_req, busy} !== 2'b00) begin
          errors++; $display("FAIL busy_fall_after_last: req,busy=%b expected 00", {sd_req, busy});
        end
      end
    end
  endtask

  task automatic test_d_ready();
    fifo_level = 11'd255; step();
    checks++;
    if (d_ready !== 1'b0) begin
      errors++; $display("FAIL d_ready_below: d_ready=%0b expected 0", d_ready);
    end
    fifo_level = 11'd256; #1;
    checks++;
    if (d_ready !== 1'b0) begin
      errors++; $display("FAIL d_ready_lag: d_ready=%0b expected 0", d_ready);
    end
    step();
    checks++;
    if (d_ready !== 1'b1) begin
      errors++; $display("FAIL d_ready_at_chunk: d_ready=%0b expected 1", d_ready);
    end
    fifo_level = '0; step();
  endtask

  task automatic test_backpressure();
    fifo_level = 11'd800; step();
    pulse_start(32'h20, 16'd1);
    repeat (6) step();
    checks++;
    if ({sd_req, d_ready, busy} !== 3'b011) begin
      errors++; $display("FAIL backpressure_hold: req,rdy,busy=%b expected 011", {sd_req, d_ready, busy});
    end
    fifo_level = 11'd769; step(); step();
    checks++;
    if (sd_req !== 1'b0) begin
      errors++; $display("FAIL backpressure_769: sd_req=%0b expected 0", sd_req);
    end
    fifo_level = 11'd768; step();
    checks++;
    if ({sd_req, d_ready} !== 2'b11) begin
      errors++; $display("FAIL req_on_space: req,rdy=%b expected 11", {sd_req, d_ready});
    end
    sd_ack = 1'b1; step(); sd_ack = 1'b0;
    sd_done = 1'b1; step(); sd_done = 1'b0;
    checks++;
    if ({busy, blocks_done} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL backpressure_end: busy=%0b blocks=%0d expected 0 1", busy, blocks_done);
    end
    fifo_level = '0; step();
  endtask

  task automatic test_stop_xfer();
    logic saw_req;
    pulse_start(32'h40, 16'd0);
    step(); step();
    sd_ack = 1'b1; step(); sd_ack = 1'b0;
    cmd_addr = 32'h999; cmd_start = 1'b1; step(); cmd_start = 1'b0;
    checks++;
    if (fifo_rst !== 1'b0) begin
      errors++; $display("FAIL start_while_busy: fifo_rst=%0b expected 0", fifo_rst);
    end
    step();
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    checks++;
    if ({busy, sd_req} !== 2'b10) begin
      errors++; $display("FAIL stopping_state: busy,req=%b expected 10", {busy, sd_req});
    end
    saw_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (sd_req) saw_req = 1'b1;
    end
    checks++;
    if (saw_req !== 1'b0) begin
      errors++; $display("FAIL no_req_while_stopping: saw sd_req=%0b expected 0", saw_req);
    end
    sd_done = 1'b1; step(); sd_done = 1'b0;
    checks++;
    if ({busy, blocks_done} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL stop_finish: busy=%0b blocks=%0d expected 0 1", busy, blocks_done);
    end
    step(); step();
    checks++;
    if (sd_req !== 1'b0) begin
      errors++; $display("FAIL no_req_after_stop: sd_req=%0b expected 0", sd_req);
    end
  endtask

  task automatic test_error();
    pulse_start(32'h80, 16'd0);
    step(); step();
    sd_ack = 1'b1; step(); sd_ack = 1'b0;
    step();
    sd_err = 1'b1; step(); sd_err = 1'b0;
    checks++;
    if ({err, busy, sd_req} !== 3'b100) begin
      errors++; $display("FAIL error_response: err,busy,req=%b expected 100", {err, busy, sd_req});
    end
    step(); step();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL error_sticky: err=%0b expected 1", err);
    end
    pulse_start(32'h90, 16'd0);
    checks++;
    if ({err, fifo_rst} !== 2'b01) begin
      errors++; $display("FAIL restart_clears_err: err,fifo_rst=%b expected 01", {err, fifo_rst});
    end
    step();
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    checks++;
    if ({busy, sd_req} !== 2'b00) begin
      errors++; $display("FAIL stop_in_issue: busy,req=%b expected 00", {busy, sd_req});
    end
  endtask

  task automatic test_addr_wrap();
    pulse_start(32'hFFFF_FFFF, 16'd2);
    step(); step();
    checks++;
    if ({sd_req, sd_addr} !== {1'b1, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL wrap_first_addr: req=%0b addr=%0h expected 1 ffffffff", sd_req, sd_addr);
    end
    sd_ack = 1'b1; step(); sd_ack = 1'b0;
    sd_done = 1'b1; step(); sd_done = 1'b0;
    step();
    checks++;
    if ({sd_req, sd_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap_addr: req=%0b addr=%0h expected 1 0", sd_req, sd_addr);
    end
    sd_ack = 1'b1; step(); sd_ack = 1'b0;
    sd_done = 1'b1; step(); sd_done = 1'b0;
    checks++;
    if ({busy, blocks_done} !== {1'b0, 16'd2}) begin
      errors++; $display("FAIL wrap_end: busy=%0b blocks=%0d expected 0 2", busy, blocks_done);
    end
  endtask

  task automatic test_simultaneous();
    cmd_addr = 32'h7; cmd_count = 16'd1; cmd_start = 1'b1; cmd_stop = 1'b1;
    step();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    checks++;
    if ({busy, fifo_rst} !== 2'b00) begin
      errors++; $display("FAIL start_stop_same: busy,fifo_rst=%b expected 00", {busy, fifo_rst});
    end
    step(); step();
    checks++;
    if ({busy, sd_req} !== 2'b00) begin
      errors++; $display("FAIL start_stop_later: busy,req=%b expected 00", {busy, sd_req});
    end
  endtask

  task automatic test_reset_wait_ack();
    fifo_level = 11'd300;
    pulse_start(32'h55, 16'd1);
    step(); step();
    checks++;
    if ({sd_req, d_ready, blocks_done} !== {2'b11, 16'd0}) begin
      errors++; $display("FAIL pre_reset_state: req=%0b rdy=%0b expected 1 1", sd_req, d_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sd_req, fifo_rst, busy, d_ready, err, blocks_done, sd_addr} !== 53'd0) begin
      errors++;
      $display("FAIL async_reset: req=%0b busy=%0b rdy=%0b addr=%0h expected all 0",
               sd_req, busy, d_ready, sd_addr);
    end
    fifo_level = '0;
    @(negedge clk);
    rst = 1'b0;
    step(); step();
    checks++;
    if ({busy, sd_req} !== 2'b00) begin
      errors++; $display("FAIL no_pending_after_reset: busy,req=%b expected 00", {busy, sd_req});
    end
  endtask

`ifdef SDREADOUT_SCHED_TIMEOUT_EN
  task automatic test_watchdog();
    int cyc;
    pulse_start(32'h200, 16'd0);
    step(); step();
    cyc = 0;
    while (!err && cyc < TO + 10) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc !== TO || busy !== 1'b0) begin
      errors++; $display("FAIL watchdog: err after %0d cycles busy=%0b expected %0d 0", cyc, busy, TO);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bounded_read();
    test_d_ready();
    test_backpressure();
    test_stop_xfer();
    test_error();
    test_addr_wrap();
    test_simultaneous();
    test_reset_wait_ack();
`ifdef SDREADOUT_SCHED_TIMEOUT_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
